// File: rtl/rom_dl_packer.sv
// rom_dl_packer
// Packs the HPS ioctl byte download stream into 16-bit word writes for the
// SDRAM ROM store. Bytes pair up into {odd, even} words. Each word goes into a
// small FIFO, and the FIFO drains through a level-request / pulse-ack write port.
// When the download ends, a trailing unpaired byte is flushed, and then done is
// raised.
//
// Optional feature macro: ROM_DL_CHECKSUM_EN adds the 16-bit checksum output.
//
// Ports:
//   clk            single clock for ioctl and SDRAM sides
//   reset          synchronous, active-high
//   ioctl_download high for the duration of a download
//   ioctl_wr       one-cycle byte strobe
//   ioctl_addr     byte address
//   ioctl_dout     byte data
//   ioctl_wait     back-pressure to the host
//   sdr_req        write request (level), held until sdr_ack
//   sdr_ack        one-cycle accept pulse
//   sdr_addr       word address (byte address >> 1)
//   sdr_data       {odd byte, even byte}
//   sdr_be         byte enables, bit0 = even byte, bit1 = odd byte
//   done           download finished and every word written
//   overflow       sticky: a byte was dropped
//   checksum       wrapping 16-bit sum of accepted bytes (ROM_DL_CHECKSUM_EN only)
module rom_dl_packer #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              sdr_req,
    input  logic              sdr_ack,
    output logic [ADDR_W-2:0] sdr_addr,
    output logic [15:0]       sdr_data,
    output logic [1:0]        sdr_be,
    output logic              done,
    output logic              overflow
`ifdef ROM_DL_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic              dl_prev_r;
    logic              done_r;
    logic              overflow_r;

    // Pending even byte waiting for its odd partner
    logic              pend_valid_r;
    logic [WA_W-1:0]   pend_waddr_r;
    logic [7:0]        pend_byte_r;

    // Odd byte whose push was postponed because the stale pending byte went first
    logic              defer_valid_r;
    logic [WA_W-1:0]   defer_waddr_r;
    logic [7:0]        defer_byte_r;

    logic [WA_W-1:0]   fifo_addr_r [FIFO_DEPTH];
    logic [15:0]       fifo_data_r [FIFO_DEPTH];
    logic [1:0]        fifo_be_r   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              sdr_req_r;
    logic [WA_W-1:0]   sdr_addr_r;
    logic [15:0]       sdr_data_r;
    logic [1:0]        sdr_be_r;

    logic              push_s;
    logic [WA_W-1:0]   push_waddr_s;
    logic [15:0]       push_data_s;
    logic [1:0]        push_be_s;
    logic              pend_set_s;
    logic              pend_clr_s;
    logic              defer_set_s;
    logic              defer_clr_s;

    logic [WA_W-1:0]   wr_waddr_s;
    logic              wr_odd_s;
    logic              dl_rise_s;
    logic              start_s;
    logic              wr_take_s;
    logic              wr_lost_s;
    logic              fifo_full_s;
    logic              push_ok_s;
    logic              push_drop_s;
    logic              pop_s;
    logic              flush_done_s;

    assign wr_waddr_s   = ioctl_addr[ADDR_W-1:1];
    assign wr_odd_s     = ioctl_addr[0];
    assign dl_rise_s    = ioctl_download & ~dl_prev_r;
    assign start_s      = dl_rise_s & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    // A host write landing while the deferred push is still outstanding has no slot
    assign wr_take_s    = (state_r == ST_LOAD) & ioctl_wr & ~defer_valid_r;
    assign wr_lost_s    = (state_r == ST_LOAD) & ioctl_wr & defer_valid_r;
    assign fifo_full_s  = (count_r == CNT_FULL);
    assign push_ok_s    = push_s & ~fifo_full_s;
    assign push_drop_s  = push_s & fifo_full_s;
    assign pop_s        = (count_r != {CNT_W{1'b0}}) & ~sdr_req_r;
    assign flush_done_s = (state_r == ST_FLUSH) & ~pend_valid_r & ~defer_valid_r &
                          (count_r == {CNT_W{1'b0}}) & ~sdr_req_r;

    // Selects the single FIFO push for this cycle and the pending/deferred updates
    always_comb begin
        push_s       = 1'b0;
        push_waddr_s = {WA_W{1'b0}};
        push_data_s  = 16'h0000;
        push_be_s    = 2'b00;
        pend_set_s   = 1'b0;
        pend_clr_s   = 1'b0;
        defer_set_s  = 1'b0;
        defer_clr_s  = 1'b0;
        if (defer_valid_r) begin
            push_s       = 1'b1;
            push_waddr_s = defer_waddr_r;
            push_data_s  = {defer_byte_r, 8'h00};
            push_be_s    = 2'b10;
            defer_clr_s  = 1'b1;
        end else if (wr_take_s) begin
            if (!wr_odd_s) begin
                // Even byte: evict any older pending byte, then wait for a partner
                if (pend_valid_r) begin
                    push_s       = 1'b1;
                    push_waddr_s = pend_waddr_r;
                    push_data_s  = {8'h00, pend_byte_r};
                    push_be_s    = 2'b01;
                end else begin
                    push_s       = 1'b0;
                end
                pend_set_s = 1'b1;
            end else if (pend_valid_r && (pend_waddr_r == wr_waddr_s)) begin
                push_s       = 1'b1;
                push_waddr_s = wr_waddr_s;
                push_data_s  = {ioctl_dout, pend_byte_r};
                push_be_s    = 2'b11;
                pend_clr_s   = 1'b1;
            end else if (pend_valid_r) begin
                // Stale pending byte goes now; the odd byte follows next cycle
                push_s       = 1'b1;
                push_waddr_s = pend_waddr_r;
                push_data_s  = {8'h00, pend_byte_r};
                push_be_s    = 2'b01;
                pend_clr_s   = 1'b1;
                defer_set_s  = 1'b1;
            end else begin
                push_s       = 1'b1;
                push_waddr_s = wr_waddr_s;
                push_data_s  = {ioctl_dout, 8'h00};
                push_be_s    = 2'b10;
            end
        end else if ((state_r == ST_FLUSH) && pend_valid_r) begin
            push_s       = 1'b1;
            push_waddr_s = pend_waddr_r;
            push_data_s  = {8'h00, pend_byte_r};
            push_be_s    = 2'b01;
            pend_clr_s   = 1'b1;
        end else begin
            push_s       = 1'b0;
        end
    end

    // Download state machine, done level and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            // Seed with the live level so a download held across reset is not a new start
            dl_prev_r  <= ioctl_download;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            dl_prev_r <= ioctl_download;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (dl_rise_s) begin
                        state_r <= ST_LOAD;
                        done_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!ioctl_download) begin
                        state_r <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_done_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            if (start_s) begin
                overflow_r <= 1'b0;
            end else if (push_drop_s || wr_lost_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Pending-byte and deferred-odd-byte registers
    always_ff @(posedge clk) begin
        if (reset || start_s) begin
            pend_valid_r  <= 1'b0;
            pend_waddr_r  <= {WA_W{1'b0}};
            pend_byte_r   <= 8'h00;
            defer_valid_r <= 1'b0;
            defer_waddr_r <= {WA_W{1'b0}};
            defer_byte_r  <= 8'h00;
        end else begin
            if (pend_set_s) begin
                pend_valid_r <= 1'b1;
                pend_waddr_r <= wr_waddr_s;
                pend_byte_r  <= ioctl_dout;
            end else if (pend_clr_s) begin
                pend_valid_r <= 1'b0;
            end
            if (defer_set_s) begin
                defer_valid_r <= 1'b1;
                defer_waddr_r <= wr_waddr_s;
                defer_byte_r  <= ioctl_dout;
            end else if (defer_clr_s) begin
                defer_valid_r <= 1'b0;
            end
        end
    end

    // FIFO storage; occupancy is defined by the pointers, so entries carry no reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_addr_r[wr_ptr_r] <= push_waddr_s;
            fifo_data_r[wr_ptr_r] <= push_data_s;
            fifo_be_r[wr_ptr_r]   <= push_be_s;
        end
    end

    // FIFO pointers and occupancy count; pointers wrap modulo the power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // SDRAM write port: the head loads only while no request is outstanding
    always_ff @(posedge clk) begin
        if (reset) begin
            sdr_req_r  <= 1'b0;
            sdr_addr_r <= {WA_W{1'b0}};
            sdr_data_r <= 16'h0000;
            sdr_be_r   <= 2'b00;
        end else if (pop_s) begin
            sdr_req_r  <= 1'b1;
            sdr_addr_r <= fifo_addr_r[rd_ptr_r];
            sdr_data_r <= fifo_data_r[rd_ptr_r];
            sdr_be_r   <= fifo_be_r[rd_ptr_r];
        end else if (sdr_req_r && sdr_ack) begin
            sdr_req_r  <= 1'b0;
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] checksum_r;
    logic [15:0] csum_add_s;

    // Sum only the bytes that actually entered the FIFO
    always_comb begin
        csum_add_s = 16'h0000;
        if (push_ok_s) begin
            csum_add_s = (push_be_s[0] ? {8'h00, push_data_s[7:0]}  : 16'h0000) +
                         (push_be_s[1] ? {8'h00, push_data_s[15:8]} : 16'h0000);
        end else begin
            csum_add_s = 16'h0000;
        end
    end

    // Running checksum, cleared at download start
    always_ff @(posedge clk) begin
        if (reset || start_s) begin
            checksum_r <= 16'h0000;
        end else begin
            checksum_r <= checksum_r + csum_add_s;
        end
    end

    assign checksum = checksum_r;
`endif

    assign ioctl_wait = (count_r >= CNT_HIGH) | defer_valid_r;
    assign sdr_req    = sdr_req_r;
    assign sdr_addr   = sdr_addr_r;
    assign sdr_data   = sdr_data_r;
    assign sdr_be     = sdr_be_r;
    assign done       = done_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Self-checking bench for rom_dl_packer. A reference model turns each byte
// stream into the list of SDRAM word writes. The list is built from the pairing
// rules, independent of timing. A responder process acks requests with random
// delay and records accepted writes, and the main sequence compares them.
module tb_rom_dl_packer;

    localparam int AW    = 25;
    localparam int DEPTH = 4;
    localparam int TOP   = (1 << AW) - 1;

    typedef struct packed {
        logic [AW-2:0] a;
        logic [15:0]   d;
        logic [1:0]    be;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          sdr_req;
    logic          sdr_ack;
    logic [AW-2:0] sdr_addr;
    logic [15:0]   sdr_data;
    logic [1:0]    sdr_be;
    logic          done;
    logic          overflow;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    int  n_vec  = 0;
    int  n_miss = 0;
    bit  ack_en = 1'b0;
    logic wait_after;

    int   dl_a[$];
    logic [7:0] dl_d[$];
    wr_t  exp_q[$];
    wr_t  got_q[$];

    rom_dl_packer #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .sdr_req        (sdr_req),
        .sdr_ack        (sdr_ack),
        .sdr_addr       (sdr_addr),
        .sdr_data       (sdr_data),
        .sdr_be         (sdr_be),
        .done           (done),
        .overflow       (overflow)
`ifdef ROM_DL_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic wr_t mk(input int wa, input logic [15:0] d, input logic [1:0] be);
        wr_t w;
        w.a  = wa[AW-2:0];
        w.d  = d;
        w.be = be;
        return w;
    endfunction

    // Reference: pair bytes into words straight from the download rules
    task automatic build_expected();
        bit         pv;
        int         pa;
        int         wa;
        logic [7:0] pb;
        exp_q.delete();
        pv = 1'b0;
        pa = 0;
        pb = 8'h00;
        foreach (dl_a[i]) begin
            wa = dl_a[i] / 2;
            if (dl_a[i] % 2 == 0) begin
                if (pv) exp_q.push_back(mk(pa, {8'h00, pb}, 2'b01));
                pv = 1'b1;
                pa = wa;
                pb = dl_d[i];
            end else if (pv && pa == wa) begin
                exp_q.push_back(mk(wa, {dl_d[i], pb}, 2'b11));
                pv = 1'b0;
            end else begin
                if (pv) exp_q.push_back(mk(pa, {8'h00, pb}, 2'b01));
                exp_q.push_back(mk(wa, {dl_d[i], 8'h00}, 2'b10));
                pv = 1'b0;
            end
        end
        if (pv) exp_q.push_back(mk(pa, {8'h00, pb}, 2'b01));
    endtask

    function automatic logic [15:0] exp_sum();
        logic [15:0] s = 16'h0000;
        foreach (exp_q[i]) begin
            if (exp_q[i].be[0]) s = s + {8'h00, exp_q[i].d[7:0]};
            if (exp_q[i].be[1]) s = s + {8'h00, exp_q[i].d[15:8]};
        end
        return s;
    endfunction

    task automatic compare_writes(input string tag);
        logic [15:0] m;
        int n;
        check({tag, "_nwr"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            m = {{8{exp_q[i].be[1]}}, {8{exp_q[i].be[0]}}};
            check($sformatf("%s_w%0d_addr", tag, i), got_q[i].a, exp_q[i].a);
            check($sformatf("%s_w%0d_be", tag, i), got_q[i].be, exp_q[i].be);
            check($sformatf("%s_w%0d_data", tag, i), got_q[i].d & m, exp_q[i].d & m);
        end
    endtask

    task automatic send_byte(input int a, input logic [7:0] d, input bit honour);
        int guard = 0;
        while (honour && ioctl_wait && guard < 1000) begin
            tick();
            guard++;
        end
        check("wait_bound", guard < 1000, 1'b1);
        ioctl_addr = a[AW-1:0];
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        wait_after = ioctl_wait;
    endtask

    task automatic start_dl();
        got_q.delete();
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        while (!done && guard < 3000) begin
            tick();
            guard++;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    // Full download honouring ioctl_wait, then compare writes and flags
    task automatic run_dl(input string tag, input bit gaps);
        build_expected();
        start_dl();
        foreach (dl_a[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_byte(dl_a[i], dl_d[i], 1'b1);
        end
        ioctl_download = 1'b0;
        wait_done(tag);
        check({tag, "_ovf"}, overflow, 1'b0);
        compare_writes(tag);
`ifdef ROM_DL_CHECKSUM_EN
        check({tag, "_csum"}, checksum, exp_sum());
`endif
    endtask

    task automatic add_byte(input int a, input logic [7:0] d);
        dl_a.push_back(a);
        dl_d.push_back(d);
    endtask

    // SDRAM side: random-latency acks, spurious acks while idle, stability checks
    initial begin
        wr_t hold;
        bit  have_hold = 1'b0;
        sdr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            sdr_ack = 1'b0;
            if (!sdr_req) begin
                have_hold = 1'b0;
            end else if (have_hold) begin
                check("stable_addr", sdr_addr, hold.a);
                check("stable_data", sdr_data, hold.d);
                check("stable_be", sdr_be, hold.be);
            end else begin
                hold = mk(int'(sdr_addr), sdr_data, sdr_be);
                have_hold = 1'b1;
            end
            if (ack_en) begin
                if (sdr_req) begin
                    if ($urandom_range(0, 1) == 0) begin
                        sdr_ack = 1'b1;
                        got_q.push_back(mk(int'(sdr_addr), sdr_data, sdr_be));
                        have_hold = 1'b0;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    sdr_ack = 1'b1;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = 8'h00;
        repeat (3) tick();
        check("rst_wait", ioctl_wait, 1'b0);
        check("rst_req", sdr_req, 1'b0);
        check("rst_addr", sdr_addr, 0);
        check("rst_data", sdr_data, 16'h0000);
        check("rst_be", sdr_be, 2'b00);
        check("rst_done", done, 1'b0);
        check("rst_ovf", overflow, 1'b0);
`ifdef ROM_DL_CHECKSUM_EN
        check("rst_csum", checksum, 16'h0000);
`endif
        reset = 1'b0;
        tick();

        // Sequential pairs
        ack_en = 1'b1;
        dl_a.delete(); dl_d.delete();
        add_byte(0, 8'h11); add_byte(1, 8'h22); add_byte(2, 8'h33); add_byte(3, 8'h44);
        run_dl("pairs", 1'b0);

        // Trailing odd byte: done must wait for the ack
        ack_en = 1'b0;
        dl_a.delete(); dl_d.delete();
        add_byte(32'h10, 8'hAA);
        build_expected();
        start_dl();
        send_byte(32'h10, 8'hAA, 1'b1);
        ioctl_download = 1'b0;
        repeat (8) tick();
        check("trail_req", sdr_req, 1'b1);
        check("trail_done_early", done, 1'b0);
        check("trail_be", sdr_be, 2'b01);
        check("trail_addr", sdr_addr, 8);
        check("trail_lo", sdr_data[7:0], 8'hAA);
        ack_en = 1'b1;
        wait_done("trail");
        compare_writes("trail");

        // Address jump: deferred odd push raises ioctl_wait
        dl_a.delete(); dl_d.delete();
        add_byte(4, 8'h55); add_byte(9, 8'h66);
        build_expected();
        start_dl();
        send_byte(4, 8'h55, 1'b1);
        send_byte(9, 8'h66, 1'b1);
        check("jump_wait", wait_after, 1'b1);
        ioctl_download = 1'b0;
        wait_done("jump");
        compare_writes("jump");

        // Back-pressure, host honouring wait, ack stalled
        ack_en = 1'b0;
        dl_a.delete(); dl_d.delete();
        for (int i = 0; i < 8; i++) add_byte(32'h100 + i, 8'(8'hA0 + i));
        build_expected();
        start_dl();
        foreach (dl_a[i]) send_byte(dl_a[i], dl_d[i], 1'b1);
        tick();
        check("bp_wait", ioctl_wait, 1'b1);
        check("bp_ovf", overflow, 1'b0);
        ack_en = 1'b1;
        ioctl_download = 1'b0;
        wait_done("bp");
        compare_writes("bp");
        check("bp_wait_low", ioctl_wait, 1'b0);

        // Back-pressure ignored: one word in the port plus DEPTH queued survive
        ack_en = 1'b0;
        dl_a.delete(); dl_d.delete();
        for (int i = 0; i < 12; i++) add_byte(32'h200 + i, 8'(8'h30 + i));
        build_expected();
        while (exp_q.size() > DEPTH + 1) void'(exp_q.pop_back());
        start_dl();
        foreach (dl_a[i]) send_byte(dl_a[i], dl_d[i], 1'b0);
        tick();
        check("ign_ovf", overflow, 1'b1);
        ack_en = 1'b1;
        ioctl_download = 1'b0;
        wait_done("ign");
        compare_writes("ign");
        check("ign_ovf_sticky", overflow, 1'b1);
`ifdef ROM_DL_CHECKSUM_EN
        check("ign_csum", checksum, exp_sum());
`endif

        // Top-of-range addresses map to the last word without wrapping
        dl_a.delete(); dl_d.delete();
        add_byte(TOP - 2, 8'h5A); add_byte(TOP - 1, 8'hC3); add_byte(TOP, 8'h3C);
        run_dl("top", 1'b1);
        check("top_last_addr", exp_q[exp_q.size() - 1].a, {(AW-1){1'b1}});
        dl_a.delete(); dl_d.delete();
        add_byte(TOP, 8'h77);
        run_dl("top1", 1'b0);

        // Randomized downloads
        for (int r = 0; r < 6; r++) begin
            dl_a.delete(); dl_d.delete();
            a = (r == 5) ? TOP - 40 : int'($urandom_range(0, 4000));
            for (int i = 0; i < int'($urandom_range(20, 60)); i++) begin
                add_byte(a, 8'($urandom_range(0, 255)));
                case ($urandom_range(0, 9))
                    7:       a = a + 2;
                    8, 9:    a = int'($urandom_range(0, TOP));
                    default: a = a + 1;
                endcase
                if (a > TOP) a = int'($urandom_range(0, 1000));
            end
            run_dl($sformatf("rnd%0d", r), r[0]);
        end

`ifdef ROM_DL_CHECKSUM_EN
        dl_a.delete(); dl_d.delete();
        for (int i = 0; i < 256; i++) add_byte(i, 8'hFF);
        run_dl("csum256", 1'b0);
        check("csum256_val", checksum, 16'hFF00);
`endif

        // Reset with a request in flight and two entries queued
        ack_en = 1'b0;
        start_dl();
        for (int i = 0; i < 6; i++) send_byte(32'h40 + i, 8'(8'h90 + i), 1'b1);
        tick();
        check("mid_req_before", sdr_req, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_wait", ioctl_wait, 1'b0);
        check("mid_req", sdr_req, 1'b0);
        check("mid_addr", sdr_addr, 0);
        check("mid_data", sdr_data, 16'h0000);
        check("mid_be", sdr_be, 2'b00);
        check("mid_done", done, 1'b0);
        check("mid_ovf", overflow, 1'b0);
        repeat (10) tick();
        check("mid_req_held", sdr_req, 1'b0);
        ioctl_download = 1'b0;
        repeat (3) tick();
        check("mid_req_after", sdr_req, 1'b0);
        check("mid_done_after", done, 1'b0);

        // Normal operation resumes after the aborted download
        ack_en = 1'b1;
        dl_a.delete(); dl_d.delete();
        add_byte(6, 8'hE1); add_byte(7, 8'hE2); add_byte(8, 8'hE3);
        run_dl("post_rst", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rom_dl_packer.md
# rom_dl_packer

Packs the HPS `ioctl` byte download stream into 16-bit word writes for the SDRAM ROM store that backs the program, tile and sprite ROMs. It sits between the MiSTer `ioctl` interface and the SDRAM controller write port, in parallel with the address-decoded on-chip EPROM loaders. It buffers words in a small FIFO, back-pressures the host with `ioctl_wait`, flushes a trailing odd byte when the download ends, and reports completion.

## Interface
- `ADDR_W`, 25: width of `ioctl_addr`, in bytes.
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, minimum 2.
- `clk` in 1: single clock for all logic; the `ioctl` and SDRAM ports are both synchronous to it.
- `reset` in 1: synchronous, active-high.
- `ioctl_download` in 1: high for the duration of a download.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_addr` in ADDR_W: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: back-pressure to the host.
- `sdr_req` out 1: write request, level.
- `sdr_ack` in 1: one-cycle accept pulse.
- `sdr_addr` out ADDR_W-1: word address, equal to byte address `[ADDR_W-1:1]`.
- `sdr_data` out 16: `{odd byte, even byte}`.
- `sdr_be` out 2: byte enables; bit0 is the even byte, bit1 the odd byte.
- `done` out 1: download completed and fully written.
- `overflow` out 1: sticky flag; a byte was dropped because the FIFO was full.
- `checksum` out 16: present only with `ROM_DL_CHECKSUM_EN`.

## Operation
- **States:** IDLE, LOAD, FLUSH, DONE.
  - Reset → IDLE.
  - IDLE/DONE → LOAD on the rising edge of `ioctl_download`. This clears `done`, `overflow`, the pending byte and (if compiled in) `checksum`.
  - LOAD → FLUSH on the falling edge of `ioctl_download`.
  - FLUSH → DONE once the pending byte is pushed, the FIFO is empty and `sdr_req` is low.
- **Pending byte register:** `{valid, word_addr, byte}`.
- **Even-address write:**
  - If a pending byte is valid, push it first with `be=01`, then latch the new byte as pending.
  - Otherwise latch it as pending.
- **Odd-address write:**
  - If the pending byte is valid and its `word_addr` matches, push `{dout, pending}` with `be=11` and clear pending.
  - If pending is valid but its address differs, push pending with `be=01` and push the odd byte with `be=10`, on consecutive cycles.
  - If nothing is pending, push the odd byte alone with `be=10`.
- **Dropped writes:** any push while the FIFO is full drops the entry and sets `overflow`. `ioctl_wr` while not in LOAD is ignored.
- **Flush:** in FLUSH, a valid pending byte is pushed with `be=01`.
- **SDRAM handshake:**
  - When the FIFO is non-empty and `sdr_req` is low, the head is popped into the output registers and `sdr_req` is set on the next edge.
  - `sdr_addr/data/be` stay stable while `sdr_req` is high.
  - `sdr_ack` clears `sdr_req` on the same edge; the next entry may raise `sdr_req` one cycle later.
  - `sdr_ack` with `sdr_req` low is ignored.
- **Back-pressure:** `ioctl_wait` = (FIFO count ≥ FIFO_DEPTH-1) OR a deferred second push (the mismatch case) is outstanding. It is combinational from registered state.
- **Reset mid-download:**
  - All state clears and the FIFO empties.
  - A request in flight is abandoned: `sdr_req` drops with no ack expected.
  - The block stays in IDLE until the next rising edge of `ioctl_download`.

## Timing
- **Reset values:** `ioctl_wait=0`, `sdr_req=0`, `sdr_addr=0`, `sdr_data=0`, `sdr_be=0`, `done=0`, `overflow=0`, `checksum=0`.
- **Latency:** completing odd `ioctl_wr` at edge N → FIFO entry at N+1 → `sdr_req` high after N+2.
- **`done`:** rises one cycle after the FLUSH exit condition holds. It is a level and stays high until the next download starts.
- **Simultaneous events:**
  - `sdr_ack` and a pop in the same cycle: the ack wins and the pop is deferred one cycle.
  - Push and pop in the same cycle: allowed; the count is unchanged.
- **Throughput:** at most one push per cycle; at most one SDRAM write every 2 cycles with a 1-cycle ack.
- **Boundaries:**
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Byte address `2^ADDR_W-1` maps to word `2^(ADDR_W-1)-1`; there is no wrap into word 0.

## Configuration
- **`ROM_DL_CHECKSUM_EN` defined:**
  - `checksum` is a 16-bit wrapping sum of every accepted byte (zero-extended).
  - It clears on download start and holds in DONE.
  - Dropped bytes are excluded.
- **`ROM_DL_CHECKSUM_EN` undefined:** the `checksum` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Sequential pairs:** bytes 0x11@0, 0x22@1, 0x33@2, 0x44@3, ack 1 cycle after each req → writes (0,0x2211,11) and (1,0x4433,11); `done` high after the last ack.
- **Trailing odd byte:** bytes 0xAA@0x10, then drop `ioctl_download` → one write (8,0x00AA or xxAA,01); `done` only after its ack.
- **Address jump:** 0x55@4, then 0x66@9 → (2,xx55,01) then (4,66xx,10). `ioctl_wait` is high for the deferred push cycle.
- **Back-pressure:** FIFO_DEPTH=4, `sdr_ack` held low, 8 contiguous bytes with the host honouring `ioctl_wait` → `ioctl_wait` rises at count 3, no `overflow`; releasing ack drains all 4 words in order. The same run with the host ignoring `ioctl_wait` → `overflow`=1 and the extra bytes are missing.
- **Reset mid-run:** `reset` pulsed while `sdr_req` is high with 2 entries queued → all outputs at reset values the next cycle; no further `sdr_req` until a new download starts.
- **Checksum** (macro on): 256 bytes of value 0xFF → `checksum`=0xFF00.
